sync_filter: RTL

- Parametrised multi-channel input synchroniser with a per-channel glitch filter. It replaces single-bit two-flop synchronisers on asynchronous inputs such as pins, straps and slow status lines.
- Each channel runs through an N-stage synchroniser chain, then a stability counter. The filtered output changes only after the synchronised value has held steady for a programmable number of cycles.
- Sits at the boundary between asynchronous inputs and the clk domain.

---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_filter_ch.sv | 67 ++++++
 rtl/sync_filter.sv | 46 ++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared constants and elaboration helpers for the sync_filter synchroniser/glitch filter.
package sync_pkg;

   localparam int SYNC_MIN_STAGES = 2;

   function automatic int sync_cnt_w(input int filt_cnt);
      return $clog2(filt_cnt + 1);
   endfunction

   function automatic bit sync_params_ok(input int stages, input int filt_cnt);
      return (stages >= SYNC_MIN_STAGES) && (filt_cnt >= 1);
   endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: STAGES-deep synchroniser chain followed by a stability counter.
// Edge pulses are built only when SYNC_FILTER_EDGE_EN is defined.
import sync_pkg::*;

module sync_filter_ch #(
   parameter int   STAGES   = 2,
   parameter int   FILT_CNT = 4,
   parameter logic RST_VAL  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_async,
   output logic out_sync,
   output logic busy
`ifdef SYNC_FILTER_EDGE_EN
   ,
   output logic rise,
   output logic fall
`endif
);

   localparam int            CW   = sync_cnt_w(FILT_CNT);
   localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
   logic [CW-1:0] cnt;
   logic          s;
   logic          upd;

   assign s   = chain[STAGES-1];
   assign upd = (s != out_sync) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain <= {STAGES{RST_VAL}};
      else      chain <= {chain[STAGES-2:0], in_async};
   end

   // Any return of s to the current output discards the pending count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         out_sync <= RST_VAL;
      end else if (s == out_sync) begin
         cnt <= '0;
      end else if (upd) begin
         cnt      <= '0;
         out_sync <= s;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign busy = |cnt;

`ifdef SYNC_FILTER_EDGE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= upd &  s;
         fall <= upd & ~s;
      end
   end
`endif

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with per-channel glitch filter.
// Define SYNC_FILTER_EDGE_EN to add the registered rise/fall pulse outputs.
import sync_pkg::*;

module sync_filter #(
   parameter int               WIDTH    = 1,
   parameter int               STAGES   = 2,
   parameter int               FILT_CNT = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_async,
   output logic [WIDTH-1:0] out_sync,
   output logic [WIDTH-1:0] busy
`ifdef SYNC_FILTER_EDGE_EN
   ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`endif
);

   if (!sync_params_ok(STAGES, FILT_CNT)) begin : g_bad_params
      $error("sync_filter: need STAGES >= %0d and FILT_CNT >= 1", SYNC_MIN_STAGES);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_filter_ch #(
         .STAGES   (STAGES),
         .FILT_CNT (FILT_CNT),
         .RST_VAL  (RST_VAL[i])
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .in_async (in_async[i]),
         .out_sync (out_sync[i]),
         .busy     (busy[i])
`ifdef SYNC_FILTER_EDGE_EN
         ,
         .rise     (rise[i]),
         .fall     (fall[i])
`endif
      );
   end

endmodule
